clk_div_bank: RTL and testbench

//   Multi-channel programmable clock divider/tick generator; successor to the fixed led divider.
//   NUM_CH independent channels, each with a runtime-loadable divide ratio, a 1-cycle tick

---
 rtl/clk_div_pkg.sv | 21 ++
 rtl/clk_div_chan.sv | 126 ++++++++++++
 rtl/clk_div_bank.sv | 90 +++++++++
 tb/tb_clk_div_bank.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the clk_div_bank programmable divider bank.
// Optional one-shot mode is enabled by defining CLK_DIV_ONESHOT_EN.
package clk_div_pkg;

  // Divide ratio loaded into every channel at reset (1 Hz from a 50 MHz clock).
  localparam int DEF_DIV_RESET = 50_000_000;

  // Reset values of the single-bit state shared by bank and channel.
  localparam logic RST_TICK    = 1'b0;
  localparam logic RST_LED     = 1'b0;
  localparam logic RST_PENDING = 1'b0;
  localparam logic RST_READY   = 1'b0;
  localparam logic RST_ERR     = 1'b0;
  localparam logic RST_DONE    = 1'b0;

  // Channel-select width; never narrower than one bit, even for a single channel.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: down-counter, active ratio, shadow ratio with pending
// flag, tick strobe and 50%-duty led toggle. The new ratio is applied only at
// a terminal count so a running period is never cut short or stretched.
// With CLK_DIV_ONESHOT_EN defined the channel gains oneshot/done ports.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = 26,
  parameter int DEF_DIV = DEF_DIV_RESET
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_div,
`ifdef CLK_DIV_ONESHOT_EN
  input  logic             oneshot,
  output logic             done,
`endif
  output logic             tick,
  output logic             led,
  output logic             pending
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             tick_q, tick_d;
  logic             led_q, led_d;
  logic [CNT_W-1:0] new_div;
  logic             terminal;
  logic             halted;

  // A requested ratio of zero behaves as one: tick every cycle.
  assign new_div  = (cfg_div == '0) ? ONE : cfg_div;
  assign terminal = (cnt_q == '0);

`ifdef CLK_DIV_ONESHOT_EN
  logic done_q, done_d;
  assign halted = done_q;
  assign done   = done_q;
`else
  assign halted = 1'b0;
`endif

  // Next-state logic: disabled channels park at div-1, enabled ones count down.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    cnt_d     = cnt_q;
    div_d     = div_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    tick_d    = 1'b0;
    led_d     = led_q;
`ifdef CLK_DIV_ONESHOT_EN
    done_d    = done_q;
`endif
    if (!en) begin
      // An update still waiting for a terminal count lands now instead.
      if (pending_q) div_d = shadow_q;
      if (cfg_we)    div_d = new_div;
      pending_d = 1'b0;
      cnt_d     = div_d - ONE;
      led_d     = 1'b0;
`ifdef CLK_DIV_ONESHOT_EN
      done_d    = 1'b0;
`endif
    end else if (!halted) begin
      if (terminal) begin
        tick_d = 1'b1;
        led_d  = ~led_q;
        if (pending_q) begin
          div_d     = shadow_q;
          pending_d = 1'b0;
        end
        cnt_d = div_d - ONE;
`ifdef CLK_DIV_ONESHOT_EN
        if (oneshot) done_d = 1'b1;
`endif
      end else begin
        cnt_d = cnt_q - ONE;
      end
    end
    // Accepted while running: park in the shadow; a same-edge terminal count
    // above has already reloaded with the old ratio.
    if (en && cfg_we) begin
      shadow_d  = new_div;
      pending_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      cnt_q     <= RST_DIV - ONE;
      div_q     <= RST_DIV;
      shadow_q  <= '0;
      pending_q <= RST_PENDING;
      tick_q    <= RST_TICK;
      led_q     <= RST_LED;
`ifdef CLK_DIV_ONESHOT_EN
      done_q    <= RST_DONE;
`endif
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      led_q     <= led_d;
`ifdef CLK_DIV_ONESHOT_EN
      done_q    <= done_d;
`endif
    end
  end

  assign tick    = tick_q;
  assign led     = led_q;
  assign pending = pending_q;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider / tick generator.
// Holds the config decode, the per-channel ready mux and the error pulse;
// the counting itself lives in clk_div_chan.
// Defining CLK_DIV_ONESHOT_EN adds the oneshot/done ports.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH   = 5,
  parameter int CNT_W    = 26,
  parameter int DEF_DIV  = DEF_DIV_RESET,
  localparam int CH_W    = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_err,
`ifdef CLK_DIV_ONESHOT_EN
  input  logic [NUM_CH-1:0] oneshot,
  output logic [NUM_CH-1:0] done,
`endif
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] led
);

  localparam int SEL_N = 1 << CH_W;

  logic [NUM_CH-1:0] pending;
  logic [SEL_N-1:0]  pending_ext;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              accept;
  logic              out_of_range;

  // Pad the pending flags so unused channel codes select a zero (always ready).
  always_comb begin
    pending_ext                = '0;
    pending_ext[NUM_CH-1:0]    = pending;
  end

  assign out_of_range = (int'(cfg_ch) >= NUM_CH);
  assign cfg_ready    = ready_q & ~pending_ext[cfg_ch];
  assign accept       = cfg_valid & cfg_ready;

  // Ready comes up one edge after reset; error pulses one cycle per bad request.
  always_comb begin
    ready_d = 1'b1;
    err_d   = accept & out_of_range;
  end

  // Bank control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q <= RST_READY;
      err_q   <= RST_ERR;
    end else begin
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign cfg_err = err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic we;
    assign we = accept & (cfg_ch == CH_W'(i));

    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (ch_en[i]),
      .cfg_we  (we),
      .cfg_div (cfg_div),
`ifdef CLK_DIV_ONESHOT_EN
      .oneshot (oneshot[i]),
      .done    (done[i]),
`endif
      .tick    (tick[i]),
      .led     (led[i]),
      .pending (pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank (NUM_CH=3, CNT_W=8, DEF_DIV=4).
// Expected tick cycles are pushed into per-channel queues as stimulus is
// driven; a negedge monitor pops and compares tick, led and cfg_err.
// The one-shot scenario is built only with CLK_DIV_ONESHOT_EN defined.
module tb_clk_div_bank;

  localparam int NCH = 3;
  localparam int DEF = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] ch_en;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_ch;
  logic [7:0]     cfg_div;
  logic           cfg_err;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] led;
`ifdef CLK_DIV_ONESHOT_EN
  logic [NCH-1:0] oneshot;
  logic [NCH-1:0] done;
`endif

  clk_div_bank #(.NUM_CH(NCH), .CNT_W(8), .DEF_DIV(DEF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_en     (ch_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
`ifdef CLK_DIV_ONESHOT_EN
    .oneshot   (oneshot),
    .done      (done),
`endif
    .tick      (tick),
    .led       (led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard and reference state.
  int exp_q [NCH][$];
  int err_q [$];
  int dv      [NCH];
  int nxt     [NCH];
  int pend    [NCH];
  int pend_at [NCH];
  bit en_m    [NCH];
  bit os_m    [NCH];
  bit halt_m  [NCH];
  bit led_exp [NCH];

  // Monitor: compare tick, led and cfg_err every cycle, mid-period.
  always @(negedge clk) begin
    for (int ch = 0; ch < NCH; ch++) begin
      bit exp_t;
      exp_t = (exp_q[ch].size() > 0) && (exp_q[ch][0] == cyc);
      if (exp_t) begin
        void'(exp_q[ch].pop_front());
        led_exp[ch] = ~led_exp[ch];
      end
      n_checks++;
      if (tick[ch] !== exp_t) begin
        n_fail++;
        $display("FAIL tick[%0d] cyc=%0d got=%b exp=%b", ch, cyc, tick[ch], exp_t);
      end
      n_checks++;
      if (led[ch] !== led_exp[ch]) begin
        n_fail++;
        $display("FAIL led[%0d] cyc=%0d got=%b exp=%b", ch, cyc, led[ch], led_exp[ch]);
      end
    end
    begin
      bit exp_e;
      exp_e = (err_q.size() > 0) && (err_q[0] == cyc);
      if (exp_e) void'(err_q.pop_front());
      n_checks++;
      if (cfg_err !== exp_e) begin
        n_fail++;
        $display("FAIL cfg_err cyc=%0d got=%b exp=%b", cyc, cfg_err, exp_e);
      end
    end
  end

  // Push expected ticks for the next n edges, then advance n edges.
  task automatic run(input int n);
    int stop;
    stop = cyc + n;
    for (int ch = 0; ch < NCH; ch++) begin
      if (en_m[ch]) begin
        while (nxt[ch] <= stop && !halt_m[ch]) begin
          exp_q[ch].push_back(nxt[ch]);
          if (pend[ch] != 0 && nxt[ch] > pend_at[ch]) begin
            dv[ch]   = pend[ch];
            pend[ch] = 0;
          end
          nxt[ch] += dv[ch];
          if (os_m[ch]) halt_m[ch] = 1'b1;
        end
      end
    end
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_ready(input int ch, input bit exp_rdy);
    cfg_ch = 2'(ch);
    #1;
    n_checks++;
    if (cfg_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL cfg_ready ch=%0d cyc=%0d got=%b exp=%b", ch, cyc, cfg_ready, exp_rdy);
    end
  endtask

  // One config handshake, accepted at the next edge.
  task automatic do_cfg(input int ch, input int div_in);
    bit exp_rdy;
    int acc;
    int eff;
    cfg_ch    = 2'(ch);
    cfg_div   = 8'(div_in);
    cfg_valid = 1'b1;
    #1;
    exp_rdy = (ch >= NCH) ? 1'b1 : (pend[ch] == 0);
    n_checks++;
    if (cfg_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL cfg_ready_req ch=%0d cyc=%0d got=%b exp=%b", ch, cyc, cfg_ready, exp_rdy);
    end
    acc = cyc + 1;
    if (ch >= NCH) begin
      err_q.push_back(acc);
    end else begin
      eff = (div_in == 0) ? 1 : div_in;
      if (en_m[ch]) begin
        pend[ch]    = eff;
        pend_at[ch] = acc;
      end else begin
        dv[ch] = eff;
      end
    end
    run(1);
    cfg_valid = 1'b0;
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      dv[ch]      = DEF;
      pend[ch]    = 0;
      halt_m[ch]  = 1'b0;
      led_exp[ch] = 1'b0;
      if (en_m[ch]) nxt[ch] = cyc + DEF;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ch_en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
`ifdef CLK_DIV_ONESHOT_EN
    oneshot = '0;
`endif
    for (int ch = 0; ch < NCH; ch++) begin
      en_m[ch] = 1'b0; os_m[ch] = 1'b0;
    end
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (tick !== 3'b000 || led !== 3'b000 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got tick=%b led=%b err=%b exp 0/0/0", tick, led, cfg_err);
    end
    check_ready(0, 1'b0);
    rst_n = 1'b1;
    run(1);
    check_ready(0, 1'b1);
  endtask

  task automatic test_periodic();
    ch_en = 3'b111;
    for (int ch = 0; ch < NCH; ch++) begin
      en_m[ch] = 1'b1;
      nxt[ch]  = cyc + dv[ch];
    end
    run(20);
  endtask

  task automatic test_cfg_pending();
    run(1);
    do_cfg(1, 6);
    check_ready(1, 1'b0);
    run(nxt[1] - cyc);
    check_ready(1, 1'b1);
    run(14);
  endtask

  task automatic test_back_to_back();
    // Accept lands on the same edge as ch0's terminal count.
    run(nxt[0] - 1 - cyc);
    do_cfg(0, 5);
    check_ready(0, 1'b0);
    run(12);
    check_ready(0, 1'b1);
  endtask

  task automatic test_div_zero();
    do_cfg(2, 0);
    run(10);
  endtask

  task automatic test_out_of_range();
    do_cfg(3, 2);
    check_ready(3, 1'b1);
    run(10);
  endtask

  task automatic test_disable_reset();
    run(1);
    ch_en[0] = 1'b0;
    en_m[0]  = 1'b0;
    run(1);
    led_exp[0] = 1'b0;
    run(3);
    do_cfg(1, 7);
    check_ready(1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    check_ready(1, 1'b0);
    run(1);
    check_ready(1, 1'b1);
    run(12);
    ch_en[0] = 1'b1;
    en_m[0]  = 1'b1;
    nxt[0]   = cyc + dv[0];
    run(9);
  endtask

`ifdef CLK_DIV_ONESHOT_EN
  task automatic test_oneshot();
    ch_en = '0;
    for (int ch = 0; ch < NCH; ch++) en_m[ch] = 1'b0;
    run(1);
    for (int ch = 0; ch < NCH; ch++) led_exp[ch] = 1'b0;
    oneshot  = 3'b001;
    os_m[0]  = 1'b1;
    ch_en    = 3'b001;
    en_m[0]  = 1'b1;
    nxt[0]   = cyc + dv[0];
    run(12);
    n_checks++;
    if (done !== 3'b001) begin
      n_fail++;
      $display("FAIL done_set got=%b exp=001", done);
    end
    ch_en   = '0;
    en_m[0] = 1'b0;
    run(1);
    led_exp[0] = 1'b0;
    n_checks++;
    if (done !== 3'b000) begin
      n_fail++;
      $display("FAIL done_clear got=%b exp=000", done);
    end
    run(2);
  endtask
`endif

  initial begin
    test_reset();
    test_periodic();
    test_cfg_pending();
    test_back_to_back();
    test_div_zero();
    test_out_of_range();
    test_disable_reset();
`ifdef CLK_DIV_ONESHOT_EN
    test_oneshot();
`endif
    run(1);
    for (int ch = 0; ch < NCH; ch++) begin
      n_checks++;
      if (exp_q[ch].size() != 0) begin
        n_fail++;
        $display("FAIL leftover_ticks ch=%0d got=%0d exp=0", ch, exp_q[ch].size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
